// File: rtl/decade_ctrl_pkg.sv
// Shared types and constants for the decade counter chain controller.
// Command opcodes, controller states and BCD digit helpers.
package decade_ctrl_pkg;

  typedef enum logic [1:0] {
    CMD_CLEAR       = 2'b00,
    CMD_LOAD_TARGET = 2'b01,
    CMD_START       = 2'b10,
    CMD_STOP        = 2'b11
  } cmd_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX = 4'd9;

  function automatic logic is_bcd_digit(bcd_digit_t d);
    return d <= BCD_MAX;
  endfunction

endpackage

// File: rtl/decade_digit.sv
// One registered BCD digit: clears, or increments 0..9 with wrap when inc is high.
// carry_out flags a digit sitting at 9 so the next digit can advance with it.
module decade_digit
  import decade_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       inc,
  output logic [3:0] q,
  output logic       carry_out
);

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc) begin
      q <= (q == BCD_MAX) ? 4'd0 : q + 4'd1;
    end
  end

  assign carry_out = (q == BCD_MAX);

endmodule

// File: rtl/decade_chain_ctrl.sv
// Command-driven sequencer for a chain of cascaded BCD digits with a prescaled
// tick, programmable terminal count, done pulse and optional auto-reload.
module decade_chain_ctrl
  import decade_ctrl_pkg::*;
#(
  parameter int DIGITS   = 2,
  parameter int PRESCALE = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [4*DIGITS-1:0]   cmd_data,
  input  logic                  auto_reload,
  output logic [4*DIGITS-1:0]   count,
  output logic                  running,
  output logic                  done,
  output logic                  err
);

  localparam int W  = 4 * DIGITS;
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRESC_LAST   = PW'(PRESCALE - 1);
  localparam logic [W-1:0]  TARGET_RESET = {DIGITS{BCD_MAX}};

  state_t          state, state_next;
  logic [PW-1:0]   presc, presc_next;
  logic [W-1:0]    target, target_next;
  logic            err_next;
  logic            done_next;

  logic            accepted;
  cmd_op_t         op;
  logic            tick;
  logic            halt;
  logic            load_ok;
  logic            count_clr;
  logic            count_adv;
  logic            all_nines;

  logic [DIGITS-1:0] inc;
  logic [DIGITS-1:0] carry;

  // Digit chain: a digit advances only when every lower digit is at 9.
  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    if (i == 0) begin : g_lsd
      assign inc[i] = count_adv;
    end else begin : g_upper
      assign inc[i] = inc[i-1] && carry[i-1];
    end

    decade_digit u_digit (
      .clk       (clk),
      .reset     (reset),
      .clr       (count_clr),
      .inc       (inc[i]),
      .q         (count[4*i +: 4]),
      .carry_out (carry[i])
    );
  end

  assign all_nines = &carry;
  assign cmd_ready = (state != ST_DONE);
  assign running   = (state == ST_RUN);

  always_comb begin
    load_ok = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (!is_bcd_digit(cmd_data[4*i +: 4])) load_ok = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= ST_IDLE;
      presc  <= '0;
      target <= TARGET_RESET;
      err    <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_next;
      presc  <= presc_next;
      target <= target_next;
      err    <= err_next;
      done   <= done_next;
    end
  end

  // NOTE: every output of this block gets a default before any branch, so no
  // path can leave a signal unassigned and infer a latch.
  always_comb begin
    state_next  = state;
    presc_next  = presc;
    target_next = target;
    err_next    = err;
    done_next   = 1'b0;
    count_clr   = 1'b0;
    count_adv   = 1'b0;

    accepted = cmd_valid && cmd_ready;
    op       = cmd_op_t'(cmd_op);
    tick     = (state == ST_RUN) && (presc == PRESC_LAST);
    halt     = accepted && ((op == CMD_CLEAR) || (op == CMD_STOP));

    unique case (state)
      ST_RUN: begin
        presc_next = tick ? '0 : presc + PW'(1);
        // Compare uses the registered target, so a same-cycle LOAD cannot affect it.
        if (tick && !halt) begin
          if (count == target) begin
            done_next = 1'b1;
            if (auto_reload) count_clr  = 1'b1;
            else             state_next = ST_DONE;
          end else begin
            count_adv = 1'b1;
            if (all_nines) count_clr = 1'b1;
          end
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
        presc_next = '0;
      end
      default: begin
        presc_next = '0;
      end
    endcase

    if (accepted) begin
      unique case (op)
        CMD_CLEAR: begin
          count_clr  = 1'b1;
          count_adv  = 1'b0;
          presc_next = '0;
          err_next   = 1'b0;
          state_next = ST_IDLE;
        end
        CMD_LOAD_TARGET: begin
          if (load_ok) target_next = cmd_data;
          else         err_next    = 1'b1;
        end
        CMD_START: begin
          if (state == ST_IDLE) begin
            state_next = ST_RUN;
            presc_next = '0;
          end
        end
        CMD_STOP: begin
          if (state == ST_RUN) begin
            state_next = ST_IDLE;
            presc_next = '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_decade_chain_ctrl.sv
// Directed bench for decade_chain_ctrl: a PRESCALE=1 instance and a PRESCALE=3
// instance, both two digits, checked against hand-computed BCD values.
module tb_decade_chain_ctrl;

  localparam logic [1:0] OP_CLEAR = 2'b00;
  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_START = 2'b10;
  localparam logic [1:0] OP_STOP  = 2'b11;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       cmd_valid, cmd_ready, auto_reload, running, done, err;
  logic [1:0] cmd_op;
  logic [7:0] cmd_data, count;

  logic       c3_valid, c3_ready, c3_auto, c3_running, c3_done, c3_err;
  logic [1:0] c3_op;
  logic [7:0] c3_data, c3_count;

  int n_checks = 0;
  int n_fail   = 0;

  decade_chain_ctrl #(.DIGITS(2), .PRESCALE(1)) dut (
    .clk(clk), .reset(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .auto_reload(auto_reload),
    .count(count), .running(running), .done(done), .err(err)
  );

  decade_chain_ctrl #(.DIGITS(2), .PRESCALE(3)) dut3 (
    .clk(clk), .reset(rst), .cmd_valid(c3_valid), .cmd_ready(c3_ready),
    .cmd_op(c3_op), .cmd_data(c3_data), .auto_reload(c3_auto),
    .count(c3_count), .running(c3_running), .done(c3_done), .err(c3_err)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] to_bcd(input int k);
    return 32'(((k / 10) % 10) * 16 + (k % 10));
  endfunction

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] op, input logic [7:0] data);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = data;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic send3(input logic [1:0] op, input logic [7:0] data);
    c3_valid = 1'b1;
    c3_op    = op;
    c3_data  = data;
    step();
    c3_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    cmd_valid = 1'b0; cmd_op = OP_CLEAR; cmd_data = '0; auto_reload = 1'b0;
    c3_valid = 1'b0; c3_op = OP_CLEAR; c3_data = '0; c3_auto = 1'b0;
    #12;
    @(negedge clk) rst = 1'b0;
    step();

    // Reset state
    check("rst_count", count, 8'h00);
    check("rst_running", running, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_ready", cmd_ready, 1'b1);
    check("rst3_count", c3_count, 8'h00);

    // Count 00..12 one per clock, then a one-cycle DONE and back to IDLE
    send(OP_LOAD, 8'h12);
    send(OP_START, 8'h00);
    check("t2_start_count", count, 8'h00);
    check("t2_start_running", running, 1'b1);
    for (int k = 1; k <= 12; k++) begin
      step();
      check("t2_count", count, to_bcd(k));
      check("t2_no_done", done, 1'b0);
    end
    step();
    check("t2_done", done, 1'b1);
    check("t2_done_ready", cmd_ready, 1'b0);
    check("t2_done_hold", count, 8'h12);
    check("t2_done_running", running, 1'b0);
    step();
    check("t2_idle_done", done, 1'b0);
    check("t2_idle_ready", cmd_ready, 1'b1);
    check("t2_idle_running", running, 1'b0);
    check("t2_idle_count", count, 8'h12);

    // Auto-reload with target 03
    send(OP_CLEAR, 8'h00);
    send(OP_LOAD, 8'h03);
    auto_reload = 1'b1;
    send(OP_START, 8'h00);
    for (int w = 0; w < 2; w++) begin
      for (int k = 1; k <= 3; k++) begin
        step();
        check("t3_count", count, to_bcd(k));
        check("t3_no_done", done, 1'b0);
      end
      step();
      check("t3_wrap_count", count, 8'h00);
      check("t3_wrap_done", done, 1'b1);
      check("t3_wrap_running", running, 1'b1);
      check("t3_wrap_ready", cmd_ready, 1'b1);
    end
    step();
    check("t3_after_done", done, 1'b0);
    check("t3_after_count", count, 8'h01);
    send(OP_STOP, 8'h00);
    check("t3_stop_running", running, 1'b0);
    auto_reload = 1'b0;

    // Bad LOAD keeps old target and sets sticky err; CLEAR drops err
    send(OP_CLEAR, 8'h00);
    send(OP_LOAD, 8'h05);
    send(OP_LOAD, 8'h1A);
    check("t4_err", err, 1'b1);
    send(OP_START, 8'h00);
    step(5);
    check("t4_count5", count, 8'h05);
    check("t4_err_sticky", err, 1'b1);
    step();
    check("t4_old_target_done", done, 1'b1);
    step();
    send(OP_CLEAR, 8'h00);
    check("t4_clear_err", err, 1'b0);
    check("t4_clear_count", count, 8'h00);

    // START with count == target fires on the first tick
    send(OP_LOAD, 8'h00);
    send(OP_START, 8'h00);
    step();
    check("t4_zero_done", done, 1'b1);
    check("t4_zero_count", count, 8'h00);
    step();

    // STOP holds, START resumes, CLEAR overrides a same-cycle tick
    send(OP_LOAD, 8'h20);
    send(OP_START, 8'h00);
    step(5);
    check("t5_at5", count, 8'h05);
    send(OP_STOP, 8'h00);
    check("t5_stop_count", count, 8'h05);
    check("t5_stop_running", running, 1'b0);
    for (int k = 0; k < 10; k++) begin
      step();
      check("t5_hold", count, 8'h05);
    end
    send(OP_START, 8'h00);
    check("t5_resume_count", count, 8'h05);
    step();
    check("t5_resume_tick", count, 8'h06);
    send(OP_CLEAR, 8'h00);
    check("t5_clr_count", count, 8'h00);
    check("t5_clr_running", running, 1'b0);
    check("t5_clr_done", done, 1'b0);

    // CLEAR on a terminal tick suppresses done
    send(OP_LOAD, 8'h02);
    send(OP_START, 8'h00);
    step(2);
    check("t5_at_target", count, 8'h02);
    send(OP_CLEAR, 8'h00);
    check("t5_term_clr_done", done, 1'b0);
    check("t5_term_clr_count", count, 8'h00);
    step();
    check("t5_term_clr_done2", done, 1'b0);

    // Same-cycle LOAD does not affect that tick's compare
    send(OP_LOAD, 8'h05);
    send(OP_START, 8'h00);
    step(3);
    check("t5_ld_at3", count, 8'h03);
    send(OP_LOAD, 8'h03);
    check("t5_ld_old_cmp", count, 8'h04);
    check("t5_ld_no_done", done, 1'b0);
    send(OP_CLEAR, 8'h00);

    // Asynchronous reset mid-run at count 07, then terminal only at 99
    send(OP_LOAD, 8'h40);
    send(OP_START, 8'h00);
    step(7);
    check("t1_at7", count, 8'h07);
    #3 rst = 1'b1;
    #1;
    check("t1_async_count", count, 8'h00);
    check("t1_async_running", running, 1'b0);
    check("t1_async_ready", cmd_ready, 1'b1);
    @(negedge clk) rst = 1'b0;
    step();
    check("t1_post_count", count, 8'h00);
    send(OP_START, 8'h00);
    for (int k = 1; k <= 99; k++) begin
      step();
      check("t1_count", count, to_bcd(k));
      check("t1_no_done", done, 1'b0);
    end
    step();
    check("t1_done99", done, 1'b1);
    check("t1_hold99", count, 8'h99);
    step();
    check("t1_idle", running, 1'b0);

    // PRESCALE=3: each value held for three clocks, done three clocks after target
    send3(OP_CLEAR, 8'h00);
    send3(OP_LOAD, 8'h02);
    send3(OP_START, 8'h00);
    check("t6_start", c3_count, 8'h00);
    for (int e = 1; e <= 8; e++) begin
      step();
      check("t6_count", c3_count, to_bcd(e / 3));
      check("t6_no_done", c3_done, 1'b0);
    end
    step();
    check("t6_done", c3_done, 1'b1);
    check("t6_done_count", c3_count, 8'h02);
    check("t6_done_ready", c3_ready, 1'b0);
    step();
    check("t6_idle", c3_running, 1'b0);

    send3(OP_CLEAR, 8'h00);
    send3(OP_LOAD, 8'h10);
    send3(OP_START, 8'h00);
    for (int e = 1; e <= 32; e++) begin
      step();
      check("t6_carry_count", c3_count, to_bcd(e / 3));
      check("t6_carry_no_done", c3_done, 1'b0);
    end
    step();
    check("t6_carry_done", c3_done, 1'b1);
    check("t6_carry_hold", c3_count, 8'h10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
